code_lock_n: RTL and testbench
==============================

Name: code_lock_n

Overview:
- Parametrised successor of the keypad code-lock controller.
- Collects CODE_LEN digits of DIGIT_W bits and compares them against an internal code register. Reports unlock or error only after all digits are entered, so no per-digit leak.
- Supports in-field reprogramming with atomic commit, a consecutive-failure lockout and an optional auto-relock timeout.
- Sits between the keypad decoder (digit + strobe) and the door actuator/status LEDs.

Parameters:
- CODE_LEN, 4, number of digits per code (2..8).
- DIGIT_W, 4, bits per digit.
- RESET_CODE, 16'h1234, code after reset, CODE_LEN*DIGIT_W bits; digit 0 = most significant DIGIT_W bits.
- MAX_TRIES, 3, consecutive failed attempts that trigger lockout (>=1).
- LOCKOUT_CYC, 16, lockout duration in CLK cycles (>=1).
- OPEN_CYC, 0, auto-relock after this many cycles in OPEN; 0 = never.

Ports:
- CLK, input, 1, system clock; all state changes on rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- digit_in, input, DIGIT_W, digit value; sampled only when enter=1.
- enter, input, 1, single-cycle digit strobe.
- program, input, 1, request program mode; level, sampled in OPEN.
- clear, input, 1, abort current entry / relock.
- enable, output, 1, unlocked indication; high only in OPEN.
- error, output, 1, one-cycle pulse on a failed attempt.
- locked_out, output, 1, high during lockout.
- prog_mode, output, 1, high in PROG.
- code_no, output, 3, index of the next digit expected (0..CODE_LEN-1).

Behaviour:
- Reset (async assert, sync release): state IDLE, code register = RESET_CODE, idx=0, fail counter=0, all timers 0.
- Outputs after reset: enable=0, error=0, locked_out=0, prog_mode=0, code_no=0.
- Outputs are registered and valid the cycle after the state change.
- States: IDLE, ENTRY, OPEN, PROG, LOCKOUT.
- IDLE:
  - enter → store mismatch flag (digit_in != code digit 0), idx=1, go to ENTRY.
  - If CODE_LEN==1, evaluate immediately as on the last digit.
- ENTRY:
  - Each enter ORs in the mismatch for digit idx and increments idx.
  - On the digit with idx==CODE_LEN-1, evaluate:
    - match → OPEN, fail counter cleared;
    - mismatch → error pulse for one cycle, fail counter +1, idx=0; if the counter reaches MAX_TRIES → LOCKOUT, else → IDLE.
  - clear → IDLE, idx=0, fail counter unchanged, no error.
- OPEN:
  - enable=1.
  - clear → IDLE.
  - program=1 → PROG, idx=0.
  - OPEN_CYC>0: after OPEN_CYC cycles with neither clear nor program → IDLE.
  - enter strobes are ignored.
- PROG:
  - Each enter writes digit_in into the shadow register at idx and increments idx.
  - After the CODE_LEN-th digit, the shadow is copied to the code register in one cycle, then → OPEN.
  - clear or program deasserted mid-sequence → abort: code register unchanged, → OPEN, idx=0.
- LOCKOUT:
  - locked_out=1 for exactly LOCKOUT_CYC cycles; all enter strobes are ignored.
  - Then → IDLE with fail counter=0.
  - clear has no effect.
- Simultaneous inputs:
  - enter+clear in the same cycle: clear wins.
  - program+clear in OPEN: clear wins.
- Counter widths:
  - idx: clog2(CODE_LEN)+1 bits.
  - Fail counter: saturates at MAX_TRIES.
  - Timers: clog2(max(LOCKOUT_CYC, OPEN_CYC))+1 bits.
- reset_n asserted in any state, including mid-PROG: immediate return to reset values; the code register reverts to RESET_CODE.
- No combinational path from any input to any output.

Decomposition:
- Package code_lock_pkg holds:
  - state encoding constants;
  - digit extraction function: digit k of a packed code, MSB-first;
  - clog2 helper.
- One sub-module, lock_timer: loadable down-counter with a done flag, shared by lockout and auto-relock (only one runs at a time).

Test Plan:
- Correct entry: reset, enter 1,2,3,4 → enable=1 the cycle after the 4th strobe; error never pulses; code_no sequence 0,1,2,3,0.
- Wrong-digit uniformity: enter 1,9,3,4 → no response until the 4th digit, then error=1 for exactly 1 cycle; enable stays 0; code_no returns 0.
- Lockout: three wrong codes in a row:
  - locked_out=1 for 16 cycles; enter 1,2,3,4 during lockout is ignored;
  - after lockout, 1,2,3,4 → enable=1.
- Reprogram:
  - unlock, assert program, enter 5,6,7,8 → OPEN; clear;
  - 1,2,3,4 → error; 5,6,7,8 → enable=1.
- Abort program: in PROG after digits 5,6, assert clear → code stays 1234; prog_mode=0; enable=1 next cycle.
- Async reset mid-ENTRY and with OPEN_CYC=10:
  - reset_n low for 1 ns mid-entry → all outputs 0 immediately;
  - with OPEN_CYC=10, after unlock enable drops after exactly 10 cycles.

Source files
------------

// File: rtl/code_lock_pkg.sv
// Shared state encoding and helpers for the parametrised keypad code lock.
package code_lock_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ENTRY   = 3'd1;
    localparam logic [2:0] ST_OPEN    = 3'd2;
    localparam logic [2:0] ST_PROG    = 3'd3;
    localparam logic [2:0] ST_LOCKOUT = 3'd4;

    localparam int MAX_CODE_W = 64;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // Digit k of a packed code, digit 0 being the most significant DIGIT_W bits.
    function automatic logic [MAX_CODE_W-1:0] get_digit(input logic [MAX_CODE_W-1:0] code,
                                                        input int k,
                                                        input int digit_w,
                                                        input int code_len);
        logic [MAX_CODE_W-1:0] mask;
        mask = (MAX_CODE_W'(1) << digit_w) - MAX_CODE_W'(1);
        return (code >> ((code_len - 1 - k) * digit_w)) & mask;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; done marks the final cycle of a loaded interval.
module lock_timer #(
    parameter int WIDTH = 5
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == WIDTH'(1));

endmodule

// File: rtl/code_lock_n.sv
// Keypad code lock: digit entry, reprogramming, failure lockout and auto-relock.
// The program request port is named prog_req because "program" is a reserved word.
module code_lock_n
    import code_lock_pkg::*;
#(
    parameter int                           CODE_LEN    = 4,
    parameter int                           DIGIT_W     = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0]  RESET_CODE  = 16'h1234,
    parameter int                           MAX_TRIES   = 3,
    parameter int                           LOCKOUT_CYC = 16,
    parameter int                           OPEN_CYC    = 0
) (
    input  logic               CLK,
    input  logic               reset_n,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               enter,
    input  logic               prog_req,
    input  logic               clear,
    output logic               enable,
    output logic               error,
    output logic               locked_out,
    output logic               prog_mode,
    output logic [2:0]         code_no
);

    localparam int CODE_W  = CODE_LEN * DIGIT_W;
    localparam int IDX_W   = clog2(CODE_LEN) + 1;
    localparam int FAIL_W  = clog2(MAX_TRIES) + 1;
    localparam int TMR_MAX = (LOCKOUT_CYC > OPEN_CYC) ? LOCKOUT_CYC : OPEN_CYC;
    localparam int TMR_W   = clog2(TMR_MAX) + 1;

    logic [2:0]        state, state_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic [FAIL_W-1:0] fail_cnt, fail_nx, fail_inc;
    logic [CODE_W-1:0] code_reg, code_nx;
    logic [CODE_W-1:0] shadow, shadow_nx, shadow_shift;
    logic              mis_flag, mis_nx, mis_now, mis_all;
    logic              last_digit, err_nx;
    logic              tmr_load, tmr_done;
    logic [TMR_W-1:0]  tmr_val;
    logic [MAX_CODE_W-1:0] code_ext;

    assign code_ext     = MAX_CODE_W'(code_reg);
    assign mis_now      = (MAX_CODE_W'(digit_in) != get_digit(code_ext, int'(idx), DIGIT_W, CODE_LEN));
    assign mis_all      = mis_flag | mis_now;
    assign last_digit   = (idx == IDX_W'(CODE_LEN - 1));
    assign fail_inc     = (fail_cnt == FAIL_W'(MAX_TRIES)) ? fail_cnt : fail_cnt + FAIL_W'(1);
    assign shadow_shift = (shadow << DIGIT_W) | CODE_W'(digit_in);

    lock_timer #(
        .WIDTH(TMR_W)
    ) u_timer (
        .CLK     (CLK),
        .reset_n (reset_n),
        .load    (tmr_load),
        .load_val(tmr_val),
        .done    (tmr_done)
    );

    // The mismatch flag accumulates silently so a wrong digit is only reported after the last one.
    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        fail_nx   = fail_cnt;
        code_nx   = code_reg;
        shadow_nx = shadow;
        mis_nx    = mis_flag;
        err_nx    = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            ST_IDLE, ST_ENTRY: begin
                if (clear) begin
                    state_nx = ST_IDLE;
                    idx_nx   = '0;
                    mis_nx   = 1'b0;
                end else if (enter) begin
                    if (last_digit) begin
                        idx_nx = '0;
                        mis_nx = 1'b0;
                        if (mis_all) begin
                            err_nx  = 1'b1;
                            fail_nx = fail_inc;
                            if (fail_inc == FAIL_W'(MAX_TRIES)) begin
                                state_nx = ST_LOCKOUT;
                                tmr_load = 1'b1;
                                tmr_val  = TMR_W'(LOCKOUT_CYC);
                            end else begin
                                state_nx = ST_IDLE;
                            end
                        end else begin
                            state_nx = ST_OPEN;
                            fail_nx  = '0;
                            tmr_load = 1'b1;
                            tmr_val  = TMR_W'(OPEN_CYC);
                        end
                    end else begin
                        state_nx = ST_ENTRY;
                        idx_nx   = idx + IDX_W'(1);
                        mis_nx   = mis_all;
                    end
                end
            end
            ST_OPEN: begin
                if (clear) begin
                    state_nx = ST_IDLE;
                end else if (prog_req) begin
                    state_nx = ST_PROG;
                    idx_nx   = '0;
                end else if (OPEN_CYC > 0 && tmr_done) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_PROG: begin
                // New digits land in the shadow; the live code only changes on a complete sequence.
                if (clear || !prog_req) begin
                    state_nx = ST_OPEN;
                    idx_nx   = '0;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(OPEN_CYC);
                end else if (enter) begin
                    shadow_nx = shadow_shift;
                    if (last_digit) begin
                        code_nx  = shadow_shift;
                        state_nx = ST_OPEN;
                        idx_nx   = '0;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(OPEN_CYC);
                    end else begin
                        idx_nx = idx + IDX_W'(1);
                    end
                end
            end
            ST_LOCKOUT: begin
                if (tmr_done) begin
                    state_nx = ST_IDLE;
                    fail_nx  = '0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                idx_nx   = '0;
                mis_nx   = 1'b0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet line up with it.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            fail_cnt   <= '0;
            code_reg   <= RESET_CODE;
            shadow     <= '0;
            mis_flag   <= 1'b0;
            enable     <= 1'b0;
            error      <= 1'b0;
            locked_out <= 1'b0;
            prog_mode  <= 1'b0;
            code_no    <= '0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            fail_cnt   <= fail_nx;
            code_reg   <= code_nx;
            shadow     <= shadow_nx;
            mis_flag   <= mis_nx;
            enable     <= (state_nx == ST_OPEN);
            error      <= err_nx;
            locked_out <= (state_nx == ST_LOCKOUT);
            prog_mode  <= (state_nx == ST_PROG);
            code_no    <= 3'(idx_nx);
        end
    end

endmodule

// File: tb/tb_code_lock_n.sv
// Scoreboard bench for code_lock_n: a digit-list reference model predicts every cycle's outputs.
module tb_code_lock_n;

    localparam int          CODE_LEN    = 4;
    localparam int          DIGIT_W     = 4;
    localparam logic [15:0] RESET_CODE  = 16'h1234;
    localparam int          MAX_TRIES   = 3;
    localparam int          LOCKOUT_CYC = 16;
    localparam int          OPEN_CYC    = 10;

    logic       CLK, reset_n, enter, prog_req, clear;
    logic [3:0] digit_in;
    logic       enable, error, locked_out, prog_mode;
    logic [2:0] code_no;

    code_lock_n #(
        .CODE_LEN   (CODE_LEN),
        .DIGIT_W    (DIGIT_W),
        .RESET_CODE (RESET_CODE),
        .MAX_TRIES  (MAX_TRIES),
        .LOCKOUT_CYC(LOCKOUT_CYC),
        .OPEN_CYC   (OPEN_CYC)
    ) dut (
        .CLK       (CLK),
        .reset_n   (reset_n),
        .digit_in  (digit_in),
        .enter     (enter),
        .prog_req  (prog_req),
        .clear     (clear),
        .enable    (enable),
        .error     (error),
        .locked_out(locked_out),
        .prog_mode (prog_mode),
        .code_no   (code_no)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int          n_checks = 0;
    int          n_errors = 0;
    string       phase = "reset";
    logic [6:0]  exp_q[$];

    typedef enum int {M_IDLE, M_ENTRY, M_OPEN, M_PROG, M_LOCK} mode_t;
    mode_t mode;
    int    code[CODE_LEN];
    int    typed[$];
    int    prog_buf[$];
    int    fails, lock_left, open_left;

    task automatic check_output(input string name, input logic [6:0] actual, input logic [6:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got en=%b err=%b lock=%b prog=%b no=%0d, want en=%b err=%b lock=%b prog=%b no=%0d",
                     name, actual[6], actual[5], actual[4], actual[3], actual[2:0],
                     expected[6], expected[5], expected[4], expected[3], expected[2:0]);
        end
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() != 0)
            check_output(phase, {enable, error, locked_out, prog_mode, code_no}, exp_q.pop_front());
    end

    task automatic model_reset();
        mode = M_IDLE;
        typed.delete();
        prog_buf.delete();
        fails     = 0;
        lock_left = 0;
        open_left = 0;
        for (int k = 0; k < CODE_LEN; k++)
            code[k] = int'((RESET_CODE >> ((CODE_LEN - 1 - k) * DIGIT_W)) & 16'h000F);
    endtask

    // Reference: keep the typed digits as a list and compare whole codes once the list is full.
    task automatic model_step(input int d, input bit e, input bit p, input bit c, output logic [6:0] expv);
        bit err, ok;
        int cnt;
        err = 1'b0;
        case (mode)
            M_IDLE, M_ENTRY: begin
                if (c) begin
                    typed.delete();
                    mode = M_IDLE;
                end else if (e) begin
                    typed.push_back(d);
                    if (typed.size() == CODE_LEN) begin
                        ok = 1'b1;
                        for (int k = 0; k < CODE_LEN; k++)
                            if (typed[k] != code[k]) ok = 1'b0;
                        typed.delete();
                        if (ok) begin
                            mode      = M_OPEN;
                            fails     = 0;
                            open_left = OPEN_CYC;
                        end else begin
                            err = 1'b1;
                            if (fails < MAX_TRIES) fails++;
                            if (fails == MAX_TRIES) begin
                                mode      = M_LOCK;
                                lock_left = LOCKOUT_CYC;
                            end else begin
                                mode = M_IDLE;
                            end
                        end
                    end else begin
                        mode = M_ENTRY;
                    end
                end
            end
            M_OPEN: begin
                if (c) mode = M_IDLE;
                else if (p) begin
                    mode = M_PROG;
                    prog_buf.delete();
                end else if (OPEN_CYC > 0) begin
                    open_left--;
                    if (open_left == 0) mode = M_IDLE;
                end
            end
            M_PROG: begin
                if (c || !p) begin
                    mode      = M_OPEN;
                    open_left = OPEN_CYC;
                    prog_buf.delete();
                end else if (e) begin
                    prog_buf.push_back(d);
                    if (prog_buf.size() == CODE_LEN) begin
                        for (int k = 0; k < CODE_LEN; k++) code[k] = prog_buf[k];
                        prog_buf.delete();
                        mode      = M_OPEN;
                        open_left = OPEN_CYC;
                    end
                end
            end
            M_LOCK: begin
                lock_left--;
                if (lock_left == 0) begin
                    mode  = M_IDLE;
                    fails = 0;
                end
            end
            default: mode = M_IDLE;
        endcase
        cnt  = (mode == M_PROG) ? prog_buf.size() : typed.size();
        expv = {mode == M_OPEN, err, mode == M_LOCK, mode == M_PROG, 3'(cnt)};
    endtask

    task automatic apply_stimulus(input int d, input bit e, input bit p, input bit c);
        logic [6:0] expv;
        digit_in = 4'(d);
        enter    = e;
        prog_req = p;
        clear    = c;
        @(posedge CLK);
        model_step(d, e, p, c, expv);
        exp_q.push_back(expv);
        #1;
    endtask

    task automatic enter_code(input int a, input int b, input int c, input int d, input bit p);
        apply_stimulus(a, 1'b1, p, 1'b0);
        apply_stimulus(b, 1'b1, p, 1'b0);
        apply_stimulus(c, 1'b1, p, 1'b0);
        apply_stimulus(d, 1'b1, p, 1'b0);
    endtask

    task automatic idle(input int n, input bit p);
        for (int i = 0; i < n; i++) apply_stimulus(0, 1'b0, p, 1'b0);
    endtask

    initial begin
        reset_n  = 1'b0;
        enter    = 1'b0;
        prog_req = 1'b0;
        clear    = 1'b0;
        digit_in = '0;
        model_reset();
        #3;
        check_output("reset", {enable, error, locked_out, prog_mode, code_no}, 7'b0);
        #9;
        reset_n = 1'b1;

        phase = "correct";
        enter_code(1, 2, 3, 4, 1'b0);
        idle(2, 1'b0);
        apply_stimulus(0, 1'b0, 1'b0, 1'b1);

        phase = "wrong";
        enter_code(1, 9, 3, 4, 1'b0);
        idle(2, 1'b0);

        phase = "lockout";
        enter_code(1, 9, 3, 4, 1'b0);
        enter_code(1, 9, 3, 4, 1'b0);
        enter_code(1, 2, 3, 4, 1'b0);
        idle(14, 1'b0);
        enter_code(1, 2, 3, 4, 1'b0);

        phase = "reprogram";
        apply_stimulus(0, 1'b0, 1'b1, 1'b0);
        enter_code(5, 6, 7, 8, 1'b1);
        apply_stimulus(0, 1'b0, 1'b0, 1'b1);
        enter_code(1, 2, 3, 4, 1'b0);
        enter_code(5, 6, 7, 8, 1'b0);

        phase = "abort_prog";
        apply_stimulus(0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(5, 1'b1, 1'b1, 1'b0);
        apply_stimulus(6, 1'b1, 1'b1, 1'b0);
        apply_stimulus(0, 1'b0, 1'b1, 1'b1);
        apply_stimulus(0, 1'b0, 1'b0, 1'b1);

        phase = "async_reset";
        apply_stimulus(1, 1'b1, 1'b0, 1'b0);
        apply_stimulus(2, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("async_reset", {enable, error, locked_out, prog_mode, code_no}, 7'b0);
        reset_n = 1'b1;
        model_reset();

        phase = "relock";
        enter_code(1, 2, 3, 4, 1'b0);
        idle(13, 1'b0);

        phase = "random";
        begin
            bit p_lvl;
            p_lvl = 1'b0;
            for (int i = 0; i < 800; i++) begin
                int d;
                bit e, c;
                if ($urandom_range(0, 7) == 0) p_lvl = ~p_lvl;
                e = ($urandom_range(0, 1) == 1);
                c = ($urandom_range(0, 19) == 0);
                if (mode != M_PROG && typed.size() < CODE_LEN && $urandom_range(0, 4) != 0)
                    d = code[typed.size()];
                else
                    d = int'($urandom_range(0, 15));
                apply_stimulus(d, e, p_lvl, c);
            end
        end

        phase = "drain";
        idle(2, 1'b0);
        @(negedge CLK);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("[TB] FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
